// File: rtl/beep_sequencer_pkg.sv
// Shared definitions for the beep sequencer: state encoding, timer width and
// the reference clock rate.
package beep_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BEEP   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int unsigned TIMER_W = 28;
  localparam int unsigned CLK_HZ  = 50000000;

  // Reload value for a phase that must last `cycles` clocks.
  function automatic logic [TIMER_W-1:0] phase_load(input int unsigned cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/beep_sequencer_beat_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module beat_timer
  import beep_sequencer_pkg::*;
(
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/beep_sequencer.sv
// Gates an incoming tone onto the buzzer as REPEAT beeps separated by silent
// gaps, reporting busy, the current beep index and a done pulse.
module beep_sequencer
  import beep_sequencer_pkg::*;
#(
  parameter int unsigned BEEP_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 12500000,
  parameter int unsigned REPEAT      = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       start,
  input  logic       tone_in,
  output logic       buzzer_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] beep_index
);

  localparam logic [TIMER_W-1:0] BEEP_LOAD  = phase_load(BEEP_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = phase_load(GAP_CYCLES);
  localparam logic [3:0]         LAST_INDEX = 4'(REPEAT - 1);

  state_t             state;
  state_t             state_next;
  logic [3:0]         index_next;
  logic               start_q;
  logic               tone_q;
  logic               launch;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  assign launch = start & ~start_q;

  beat_timer u_beat_timer (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .load     (timer_load),
    .value    (timer_value),
    .zero     (timer_zero)
  );

  always_comb begin
    state_next  = state;
    index_next  = beep_index;
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_next  = BEEP;
          index_next  = '0;
          timer_load  = 1'b1;
          timer_value = BEEP_LOAD;
        end
      end
      BEEP: begin
        if (timer_zero) begin
          if (beep_index == LAST_INDEX) begin
            state_next = FINISH;
          end else begin
            state_next  = GAP;
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (timer_zero) begin
          state_next  = BEEP;
          index_next  = beep_index + 4'd1;
          timer_load  = 1'b1;
          timer_value = BEEP_LOAD;
        end
      end
      FINISH: begin
        state_next = IDLE;
        index_next = '0;
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  // Outputs decode the next state so busy, done and the buzzer envelope all
  // change on the same edge as the state register.
  always_ff @(posedge clock_in) begin
    // start_q keeps tracking during reset so a start held through reset
    // cannot masquerade as a fresh rising edge afterwards.
    start_q <= start;
    if (!reset_n) begin
      state      <= IDLE;
      beep_index <= '0;
      tone_q     <= 1'b0;
      buzzer_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      beep_index <= index_next;
      tone_q     <= tone_in;
      buzzer_out <= tone_q & (state_next == BEEP);
      busy       <= (state_next != IDLE);
      done       <= (state_next == FINISH);
    end
  end

endmodule
